// File: rtl/vga_fetch_unit.sv
// VGA framebuffer fetch client: per visible line it reads WORDS_PER_LINE words through the
// request_handler VGA port and queues them in a small FIFO for the pixel serializer.
module vga_fetch_unit #(
  parameter logic [31:0] FB_BASE        = 32'h0000_2000,
  parameter int          WORDS_PER_LINE = 20,
  parameter int          LINES          = 480,
  parameter int          READY_CYCLES   = 2,
  parameter int          FIFO_DEPTH     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic        line_start,
  input  logic        pixel_pop,
  input  logic        mem_busy,
  input  logic [31:0] data_to_VGA,
  output logic [1:0]  VGA_state,
  output logic        read_from_VGA,
  output logic        write_from_VGA,
  output logic [31:0] adr_from_VGA,
  output logic [31:0] data_from_VGA,
  output logic [3:0]  sel_from_VGA,
  output logic [31:0] pixel_word,
  output logic        pixel_valid,
  output logic        underflow,
  output logic        overrun
);
  localparam logic [1:0] S_INACTIVE = 2'b00;
  localparam logic [1:0] S_READY    = 2'b01;
  localparam logic [1:0] S_ACTIVE   = 2'b10;

  localparam int LW = $clog2(LINES + 1);
  localparam int WW = $clog2(WORDS_PER_LINE + 1);
  localparam int RW = $clog2(READY_CYCLES + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [1:0]    state;
  logic [LW-1:0] line_cnt;
  logic [WW-1:0] word_cnt;
  logic [RW-1:0] ready_cnt;
  logic          outstanding;

  logic [31:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] fifo_count;
  logic [31:0]   last_word;

  logic          fifo_empty;
  logic          accept;
  logic          push;
  logic          pop;
  logic          last_push;
  logic [31:0]   word_index;

  assign fifo_empty    = (fifo_count == '0);
  // Holding the issue gate on fifo_count guarantees the single in-flight word always has a slot.
  assign read_from_VGA = (state == S_ACTIVE) && !outstanding && (fifo_count < CW'(FIFO_DEPTH));
  assign accept        = read_from_VGA && !mem_busy && !frame_start;
  assign push          = outstanding && !mem_busy && !frame_start;
  assign pop           = pixel_pop && !fifo_empty && !frame_start;
  assign last_push     = push && (word_cnt == WW'(WORDS_PER_LINE - 1));

  assign word_index     = 32'(line_cnt) * 32'(WORDS_PER_LINE) + 32'(word_cnt);
  assign adr_from_VGA   = read_from_VGA ? FB_BASE + (word_index << 2) : 32'h0;
  assign sel_from_VGA   = read_from_VGA ? 4'b1111 : 4'b0000;
  assign write_from_VGA = 1'b0;
  assign data_from_VGA  = 32'h0;
  assign VGA_state      = state;
  assign pixel_valid    = !fifo_empty;
  assign pixel_word     = fifo_empty ? last_word : fifo_mem[rd_ptr];

  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_INACTIVE;
      line_cnt    <= '0;
      word_cnt    <= '0;
      ready_cnt   <= '0;
      outstanding <= 1'b0;
    end else if (frame_start) begin
      state       <= S_INACTIVE;
      line_cnt    <= '0;
      word_cnt    <= '0;
      ready_cnt   <= '0;
      outstanding <= 1'b0;
    end else begin
      case (state)
        S_INACTIVE: begin
          if (line_start && (line_cnt < LW'(LINES))) begin
            state     <= S_READY;
            ready_cnt <= '0;
          end
        end
        S_READY: begin
          ready_cnt <= ready_cnt + 1'b1;
          if (ready_cnt == RW'(READY_CYCLES - 1)) state <= S_ACTIVE;
        end
        S_ACTIVE: begin
          if (accept) outstanding <= 1'b1;
          if (push) begin
            outstanding <= 1'b0;
            if (last_push) begin
              word_cnt <= '0;
              line_cnt <= line_cnt + 1'b1;
              state    <= S_INACTIVE;
            end else begin
              word_cnt <= word_cnt + 1'b1;
            end
          end
        end
        default: state <= S_INACTIVE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underflow <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      underflow <= pixel_pop && fifo_empty;
      overrun   <= line_start && !frame_start && (state != S_INACTIVE);
    end
  end

  // last_word lets pixel_word hold its previous value while the FIFO is empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      last_word  <= '0;
    end else begin
      last_word <= pixel_word;
      if (frame_start) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fifo_count <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   fifo_count <= fifo_count + 1'b1;
          2'b01:   fifo_count <= fifo_count - 1'b1;
          default: fifo_count <= fifo_count;
        endcase
      end
    end
  end

  // NOTE: FIFO storage has no reset; fifo_count gates every read of it, so contents never leak.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= data_to_VGA;
  end

endmodule

// File: tb/tb_vga_fetch_unit.sv
// Self-checking bench for vga_fetch_unit: directed table, corner sequences, then random
// traffic against a transaction-level model (address arithmetic + FIFO queue).
module tb_vga_fetch_unit;
  localparam int          WPL  = 4;
  localparam int          NL   = 2;
  localparam int          RC   = 2;
  localparam int          FD   = 4;
  localparam logic [31:0] BASE = 32'h0000_2000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_start = 1'b0;
  logic        line_start = 1'b0;
  logic        pixel_pop = 1'b0;
  logic        mem_busy = 1'b0;
  logic [31:0] data_to_VGA = 32'h0;
  logic [1:0]  VGA_state;
  logic        read_from_VGA;
  logic        write_from_VGA;
  logic [31:0] adr_from_VGA;
  logic [31:0] data_from_VGA;
  logic [3:0]  sel_from_VGA;
  logic [31:0] pixel_word;
  logic        pixel_valid;
  logic        underflow;
  logic        overrun;

  vga_fetch_unit #(
    .FB_BASE(BASE), .WORDS_PER_LINE(WPL), .LINES(NL), .READY_CYCLES(RC), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .line_start(line_start),
    .pixel_pop(pixel_pop), .mem_busy(mem_busy), .data_to_VGA(data_to_VGA),
    .VGA_state(VGA_state), .read_from_VGA(read_from_VGA), .write_from_VGA(write_from_VGA),
    .adr_from_VGA(adr_from_VGA), .data_from_VGA(data_from_VGA), .sel_from_VGA(sel_from_VGA),
    .pixel_word(pixel_word), .pixel_valid(pixel_valid), .underflow(underflow), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference model
  int          m_line, m_word, m_ready;
  bit          m_active, m_out, m_uf, m_ov;
  logic [31:0] q[$];
  logic [31:0] m_last;

  function automatic bit m_idle();
    return !m_active && (m_ready == 0);
  endfunction

  function automatic logic [31:0] exp_addr();
    return BASE + 32'((m_line * WPL + m_word) * 4);
  endfunction

  task automatic model_reset();
    m_line = 0; m_word = 0; m_ready = 0;
    m_active = 0; m_out = 0; m_uf = 0; m_ov = 0;
    q.delete();
    m_last = 32'h0;
  endtask

  // Called at a falling edge: checks outputs, drives inputs, advances the model by one edge.
  task automatic cycle(input bit fs, input bit ls, input bit pop, input bit busy,
                       input logic [31:0] data);
    bit          exp_read;
    bit          was_idle;
    logic [1:0]  exp_state;
    logic [31:0] head;
    exp_read  = m_active && !m_out && (q.size() < FD);
    exp_state = m_active ? 2'd2 : ((m_ready > 0) ? 2'd1 : 2'd0);
    head      = (q.size() != 0) ? q[0] : m_last;
    check("VGA_state", 32'(VGA_state), 32'(exp_state));
    check("read", 32'(read_from_VGA), 32'(exp_read));
    check("adr", adr_from_VGA, exp_read ? exp_addr() : 32'h0);
    check("sel", 32'(sel_from_VGA), exp_read ? 32'hF : 32'h0);
    check("pixel_valid", 32'(pixel_valid), 32'(q.size() != 0));
    check("pixel_word", pixel_word, head);
    check("underflow", 32'(underflow), 32'(m_uf));
    check("overrun", 32'(overrun), 32'(m_ov));
    check("tie_offs", data_from_VGA | 32'(write_from_VGA), 32'h0);
    m_last = head;

    frame_start = fs; line_start = ls; pixel_pop = pop; mem_busy = busy; data_to_VGA = data;

    was_idle = m_idle();
    m_uf = pop && (q.size() == 0);
    m_ov = ls && !was_idle && !fs;
    if (fs) begin
      m_line = 0; m_word = 0; m_ready = 0; m_active = 0; m_out = 0;
      q.delete();
    end else begin
      if (pop && q.size() != 0) void'(q.pop_front());
      if (m_out && !busy) begin
        q.push_back(data);
        m_out = 0;
        m_word++;
        if (m_word == WPL) begin
          m_word = 0; m_line++; m_active = 0;
        end
      end else if (exp_read && !busy) begin
        m_out = 1;
      end
      if (m_ready > 0) begin
        m_ready--;
        if (m_ready == 0) m_active = 1;
      end else if (ls && was_idle && m_line < NL) begin
        m_ready = RC;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 32'h0);
  endtask

  // Run the current line to completion with no stalls; data tagged by word number.
  task automatic run_line(input logic [31:0] tag);
    int n = 0;
    while (!m_idle() && n < 40) begin
      cycle(0, 0, 0, 0, tag + 32'(m_word));
      n++;
    end
    checks++;
    if (!m_idle()) begin
      errors++;
      $display("FAIL run_line: line not finished after %0d cycles", n);
    end
  endtask

  typedef struct {
    bit          fs;
    bit          ls;
    logic [31:0] data;
    logic [1:0]  st;
    bit          rd;
    logic [31:0] adr;
  } vec_t;

  vec_t tbl[13];

  function automatic vec_t mk(bit fs, bit ls, logic [31:0] data, logic [1:0] st, bit rd,
                              logic [31:0] adr);
    vec_t v;
    v.fs = fs; v.ls = ls; v.data = data; v.st = st; v.rd = rd; v.adr = adr;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int reads;
    tbl[0]  = mk(1, 0, 32'h0,  2'd0, 0, 32'h0);
    tbl[1]  = mk(0, 1, 32'h0,  2'd0, 0, 32'h0);
    tbl[2]  = mk(0, 0, 32'h0,  2'd1, 0, 32'h0);
    tbl[3]  = mk(0, 0, 32'h0,  2'd1, 0, 32'h0);
    tbl[4]  = mk(0, 0, 32'h0,  2'd2, 1, 32'h2000);
    tbl[5]  = mk(0, 0, 32'hA0, 2'd2, 0, 32'h0);
    tbl[6]  = mk(0, 0, 32'h0,  2'd2, 1, 32'h2004);
    tbl[7]  = mk(0, 0, 32'hA1, 2'd2, 0, 32'h0);
    tbl[8]  = mk(0, 0, 32'h0,  2'd2, 1, 32'h2008);
    tbl[9]  = mk(0, 0, 32'hA2, 2'd2, 0, 32'h0);
    tbl[10] = mk(0, 0, 32'h0,  2'd2, 1, 32'h200C);
    tbl[11] = mk(0, 0, 32'hA3, 2'd2, 0, 32'h0);
    tbl[12] = mk(0, 0, 32'h0,  2'd0, 0, 32'h0);

    // 1: reset
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_state", 32'(VGA_state), 32'h0);
    check("rst_outputs", {27'h0, read_from_VGA, pixel_valid, underflow, overrun, write_from_VGA}, 32'h0);
    check("rst_adr", adr_from_VGA, 32'h0);
    check("rst_pixel_word", pixel_word, 32'h0);

    // 2: first line, table-driven
    for (int i = 0; i < 13; i++) begin
      check($sformatf("tbl%0d_state", i), 32'(VGA_state), 32'(tbl[i].st));
      check($sformatf("tbl%0d_read", i), 32'(read_from_VGA), 32'(tbl[i].rd));
      check($sformatf("tbl%0d_adr", i), adr_from_VGA, tbl[i].adr);
      cycle(tbl[i].fs, tbl[i].ls, 0, 0, tbl[i].data);
    end
    for (int i = 0; i < 4; i++) begin
      check("fifo_order", pixel_word, 32'hA0 + 32'(i));
      cycle(0, 0, 1, 0, 32'h0);
    end
    check("fifo_drained", 32'(pixel_valid), 32'h0);

    // 3: stall with request held
    cycle(0, 1, 0, 0, 32'h0);
    idle_cycles(2);
    for (int i = 0; i < 5; i++) begin
      check("stall_adr", adr_from_VGA, 32'h2010);
      check("stall_sel", 32'(sel_from_VGA), 32'hF);
      cycle(0, 0, 0, 1, 32'h0);
    end
    run_line(32'hB0);
    check("line2_done_state", 32'(VGA_state), 32'h0);
    cycle(0, 1, 0, 0, 32'h0);
    idle_cycles(3);
    check("ls_past_last_line", 32'(VGA_state), 32'h0);
    check("ls_past_last_no_overrun", 32'(overrun), 32'h0);

    // 4: full FIFO blocks issue; one pop buys one read
    cycle(1, 0, 0, 0, 32'h0);
    cycle(0, 1, 0, 0, 32'h0);
    run_line(32'hC0);
    cycle(0, 1, 0, 0, 32'h0);
    idle_cycles(2);
    for (int i = 0; i < 4; i++) begin
      check("full_active", 32'(VGA_state), 32'h2);
      check("full_no_read", 32'(read_from_VGA), 32'h0);
      idle_cycles(1);
    end
    cycle(0, 0, 1, 0, 32'h0);
    reads = 0;
    for (int i = 0; i < 6; i++) begin
      if (read_from_VGA) reads++;
      cycle(0, 0, 0, 0, 32'hD0);
    end
    check("one_pop_one_read", 32'(reads), 32'h1);

    // 5: frame_start with a read outstanding
    cycle(0, 0, 1, 0, 32'h0);
    check("refill_read", 32'(read_from_VGA), 32'h1);
    cycle(0, 0, 0, 0, 32'h0);
    check("outstanding_read_low", 32'(read_from_VGA), 32'h0);
    cycle(1, 0, 0, 0, 32'hDEAD_BEEF);
    check("flush_state", 32'(VGA_state), 32'h0);
    check("flush_valid", 32'(pixel_valid), 32'h0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 32'hDEAD_BEEF);
    check("late_return_dropped", 32'(pixel_valid), 32'h0);

    // 6: underflow and overrun pulses
    cycle(0, 0, 1, 0, 32'h0);
    check("underflow_pulse", 32'(underflow), 32'h1);
    idle_cycles(1);
    check("underflow_clear", 32'(underflow), 32'h0);
    cycle(0, 1, 0, 0, 32'h0);
    idle_cycles(2);
    cycle(0, 1, 0, 0, 32'h0);
    check("overrun_pulse", 32'(overrun), 32'h1);
    idle_cycles(1);
    check("overrun_clear", 32'(overrun), 32'h0);
    run_line(32'hE0);

    // reset mid-fetch
    cycle(1, 0, 0, 0, 32'h0);
    cycle(0, 1, 0, 0, 32'h0);
    idle_cycles(3);
    rst = 1'b1;
    frame_start = 1'b0; line_start = 1'b0; pixel_pop = 1'b0; mem_busy = 1'b0;
    #1;
    check("midrst_state", 32'(VGA_state), 32'h0);
    check("midrst_outputs", {27'h0, read_from_VGA, pixel_valid, underflow, overrun, write_from_VGA}, 32'h0);
    check("midrst_adr", adr_from_VGA, 32'h0);
    check("midrst_pixel_word", pixel_word, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bit fs, ls, pop, busy;
      if (m_idle() && m_line == NL) fs = ($urandom_range(0, 19) == 0);
      else                          fs = ($urandom_range(0, 299) == 0);
      ls   = m_idle() ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 49) == 0);
      pop  = ($urandom_range(0, 1) == 1);
      busy = ($urandom_range(0, 99) < 30);
      cycle(fs, ls, pop, busy, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
